// File: rtl/player_ship_pkg.sv
// Shared parameters and types for the player_ship block: fire FSM state
// encoding, default playfield size and default ship colour.
package player_ship_pkg;

  typedef enum logic [1:0] {
    READY,
    PENDING,
    COOLDOWN
  } fire_state_t;

  localparam int unsigned DEF_HRES       = 640;
  localparam int unsigned DEF_VRES       = 480;
  localparam logic [23:0] DEF_SHIP_COLOR = 24'h00FF00;

endpackage

// File: rtl/player_ship_if.sv
// Fire-request handshake between the player ship (master) and the
// projectile spawner (slave).
interface player_ship_if;
  logic               fire_req;
  logic signed [11:0] fire_x;
  logic               fire_ack;

  modport master (output fire_req, output fire_x, input fire_ack);
  modport slave  (input fire_req, input fire_x, output fire_ack);
endinterface

// File: rtl/player_ship_btn_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter.
// `rise` pulses for one cycle in the first cycle `level` reads high.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // Counter only runs while the synchronised input disagrees with the level
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/player_ship.sv
// Player ship controller: debounced buttons, per-frame velocity/position
// with edge clamp, ship sprite output. Fire handshake built only when
// PLAYER_SHIP_FIRE_EN is defined; otherwise fire_req/fire_x are tied to 0.
module player_ship
  import player_ship_pkg::*;
#(
  parameter int          HRES            = DEF_HRES,
  parameter int          VRES            = DEF_VRES,
  parameter int          SHIP_W          = 32,
  parameter int          SHIP_H          = 16,
  parameter int          MAX_VEL         = 8,
  parameter int          ACCEL           = 2,
  parameter int          FRICTION        = 1,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          FIRE_COOLDOWN   = 8,
  parameter logic [23:0] SHIP_COLOR      = DEF_SHIP_COLOR
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               fsync,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic               right,
  input  logic               left,
  input  logic               fire,
  output logic [7:0]         pixel [0:2],
  output logic               active,
  output logic signed [11:0] ship_x,
  output logic signed [11:0] ship_center_x,
  output logic signed [7:0]  ship_vel,
  player_ship_if.master      fire_bus
);

  localparam logic signed [11:0] X_RESET = 12'((HRES - SHIP_W) / 2);
  localparam logic signed [11:0] HALF_W  = 12'(SHIP_W / 2);
  localparam logic signed [12:0] X_MAX   = 13'(HRES - SHIP_W);
  localparam logic signed [12:0] W_13    = 13'(SHIP_W);
  localparam logic signed [12:0] Y_TOP   = 13'(VRES - SHIP_H);
  localparam logic signed [12:0] Y_END   = 13'(VRES);
  localparam logic signed [9:0]  V_MAX   = 10'(MAX_VEL);
  localparam logic signed [9:0]  V_ACC   = 10'(ACCEL);
  localparam logic signed [9:0]  V_FRI   = 10'(FRICTION);

  logic lvl_r, lvl_l, unused_rise_r, unused_rise_l;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(pixel_clk), .rst_n(rst_n), .btn(right), .level(lvl_r), .rise(unused_rise_r)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(pixel_clk), .rst_n(rst_n), .btn(left), .level(lvl_l), .rise(unused_rise_l)
  );

  logic               want_r_q, want_l_q;
  logic signed [11:0] ship_x_q, ship_x_d;
  logic signed [7:0]  vel_q, vel_d;
  logic signed [9:0]  vel_w, vel_t;
  logic signed [12:0] x_t;

  assign vel_w = {{2{vel_q[7]}}, vel_q};

  always_comb begin
    vel_t = vel_w;
    if (want_r_q && !want_l_q) begin
      vel_t = vel_w + V_ACC;
      if (vel_t > V_MAX) vel_t = V_MAX;
    end else if (want_l_q && !want_r_q) begin
      vel_t = vel_w - V_ACC;
      if (vel_t < -V_MAX) vel_t = -V_MAX;
    end else if (vel_w > V_FRI) begin
      vel_t = vel_w - V_FRI;
    end else if (vel_w < -V_FRI) begin
      vel_t = vel_w + V_FRI;
    end else begin
      vel_t = '0;
    end

    x_t      = {ship_x_q[11], ship_x_q} + {{5{vel_t[7]}}, vel_t[7:0]};
    vel_d    = vel_t[7:0];
    ship_x_d = x_t[11:0];
    if (x_t < 0) begin
      ship_x_d = '0;
      vel_d    = '0;
    end else if (x_t > X_MAX) begin
      ship_x_d = X_MAX[11:0];
      vel_d    = '0;
    end
  end

  // Level present on the fsync cycle seeds the next frame's intent
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      want_r_q <= 1'b0;
      want_l_q <= 1'b0;
      ship_x_q <= X_RESET;
      vel_q    <= '0;
    end else if (fsync) begin
      want_r_q <= lvl_r;
      want_l_q <= lvl_l;
      ship_x_q <= ship_x_d;
      vel_q    <= vel_d;
    end else begin
      want_r_q <= want_r_q | lvl_r;
      want_l_q <= want_l_q | lvl_l;
    end
  end

  assign ship_x        = ship_x_q;
  assign ship_vel      = vel_q;
  assign ship_center_x = ship_x_q + HALF_W;

  logic signed [12:0] hpos_w, vpos_w, x_w;

  assign hpos_w = {hpos[11], hpos};
  assign vpos_w = {vpos[11], vpos};
  assign x_w    = {ship_x_q[11], ship_x_q};
  assign active = (hpos_w >= x_w) && (hpos_w < x_w + W_13) &&
                  (vpos_w >= Y_TOP) && (vpos_w < Y_END);

  assign pixel[0] = active ? SHIP_COLOR[7:0]   : '0;
  assign pixel[1] = active ? SHIP_COLOR[15:8]  : '0;
  assign pixel[2] = active ? SHIP_COLOR[23:16] : '0;

`ifdef PLAYER_SHIP_FIRE_EN
  localparam int COOL_W = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

  logic               lvl_f, rise_f;
  fire_state_t        state_q, state_d;
  logic [COOL_W-1:0]  cool_q, cool_d;
  logic signed [11:0] fire_x_q, fire_x_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
    .clk(pixel_clk), .rst_n(rst_n), .btn(fire), .level(lvl_f), .rise(rise_f)
  );

  always_comb begin
    state_d  = state_q;
    cool_d   = cool_q;
    fire_x_d = fire_x_q;
    case (state_q)
      READY: begin
        if (rise_f) begin
          state_d  = PENDING;
          fire_x_d = ship_center_x;
        end
      end
      PENDING: begin
        if (fire_bus.fire_ack) begin
          if (FIRE_COOLDOWN == 0) begin
            state_d = READY;
          end else begin
            state_d = COOLDOWN;
            cool_d  = COOL_W'(FIRE_COOLDOWN);
          end
        end
      end
      COOLDOWN: begin
        if (fsync) begin
          if (cool_q <= COOL_W'(1)) begin
            state_d = READY;
            cool_d  = '0;
          end else begin
            cool_d = cool_q - 1'b1;
          end
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= READY;
      cool_q   <= '0;
      fire_x_q <= '0;
    end else begin
      state_q  <= state_d;
      cool_q   <= cool_d;
      fire_x_q <= fire_x_d;
    end
  end

  assign fire_bus.fire_req = (state_q == PENDING);
  assign fire_bus.fire_x   = fire_x_q;
`else
  logic unused_fire;

  assign unused_fire       = fire ^ fire_bus.fire_ack ^ (FIRE_COOLDOWN != 0);
  assign fire_bus.fire_req = 1'b0;
  assign fire_bus.fire_x   = '0;
`endif

endmodule

// File: tb/tb_player_ship.sv
// Directed bench for player_ship with default parameters: sprite window
// table, per-frame motion table, clamp, glitch and fire handshake sequences.
module tb_player_ship;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               fsync;
  logic signed [11:0] hpos, vpos;
  logic               right, left, fire;
  logic [7:0]         pixel [0:2];
  logic               active;
  logic signed [11:0] ship_x, ship_center_x;
  logic signed [7:0]  ship_vel;

  int total = 0;
  int bad   = 0;

  player_ship_if bus ();

  player_ship dut (
    .pixel_clk(clk), .rst_n(rst_n), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .right(right), .left(left), .fire(fire), .pixel(pixel), .active(active),
    .ship_x(ship_x), .ship_center_x(ship_center_x), .ship_vel(ship_vel),
    .fire_bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   h;
    int   v;
    int   act;
    int   rgb;
  } pix_vec_t;

  typedef struct {
    logic r;
    logic l;
    int   vel;
    int   x;
  } mot_vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Buttons held for `hold` cycles, released long enough to settle, then fsync
  task automatic run_frame(input logic r, input logic l, input logic f, input int hold);
    right = r; left = l; fire = f;
    repeat (hold) @(negedge clk);
    right = 1'b0; left = 1'b0; fire = 1'b0;
    repeat (12) @(negedge clk);
    fsync = 1'b1;
    @(negedge clk);
    fsync = 1'b0;
  endtask

  pix_vec_t pv [9];
  mot_vec_t mv [17];
  int n;

  initial begin
    pv[0] = '{320, 470, 1, 32'h00FF00};
    pv[1] = '{300, 470, 0, 0};
    pv[2] = '{304, 464, 1, 32'h00FF00};
    pv[3] = '{303, 464, 0, 0};
    pv[4] = '{335, 479, 1, 32'h00FF00};
    pv[5] = '{336, 479, 0, 0};
    pv[6] = '{320, 463, 0, 0};
    pv[7] = '{320, 480, 0, 0};
    pv[8] = '{-5,  470, 0, 0};

    mv[0]  = '{1'b1, 1'b0,  2, 306};
    mv[1]  = '{1'b1, 1'b0,  4, 310};
    mv[2]  = '{1'b1, 1'b0,  6, 316};
    mv[3]  = '{1'b1, 1'b0,  8, 324};
    mv[4]  = '{1'b1, 1'b0,  8, 332};
    mv[5]  = '{1'b0, 1'b0,  7, 339};
    mv[6]  = '{1'b0, 1'b0,  6, 345};
    mv[7]  = '{1'b1, 1'b1,  5, 350};
    mv[8]  = '{1'b1, 1'b1,  4, 354};
    mv[9]  = '{1'b1, 1'b1,  3, 357};
    mv[10] = '{1'b1, 1'b1,  2, 359};
    mv[11] = '{1'b1, 1'b1,  1, 360};
    mv[12] = '{1'b1, 1'b1,  0, 360};
    mv[13] = '{1'b1, 1'b1,  0, 360};
    mv[14] = '{1'b0, 1'b1, -2, 358};
    mv[15] = '{1'b0, 1'b1, -4, 354};
    mv[16] = '{1'b0, 1'b0, -3, 351};

    rst_n = 1'b0; fsync = 1'b0; right = 1'b0; left = 1'b0; fire = 1'b0;
    hpos = '0; vpos = '0; bus.fire_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset_ship_x", ship_x, 304);
    chk("reset_center", ship_center_x, 320);
    chk("reset_vel", ship_vel, 0);
    chk("reset_fire_req", bus.fire_req, 0);
    chk("reset_fire_x", bus.fire_x, 0);

    foreach (pv[i]) begin
      hpos = 12'(pv[i].h);
      vpos = 12'(pv[i].v);
      #1;
      chk("pix_active", active, pv[i].act);
      chk("pix_rgb", int'({pixel[2], pixel[1], pixel[0]}), pv[i].rgb);
    end
    @(negedge clk);

`ifdef PLAYER_SHIP_FIRE_EN
    fire = 1'b1;
    n = 0;
    while (!bus.fire_req && n < 20) begin @(negedge clk); n++; end
    chk("fire_latency", n, 7);
    chk("fire_x_first", bus.fire_x, 320);
    fire = 1'b0;
    repeat (10) @(negedge clk);
    chk("fire_req_held", bus.fire_req, 1);
    bus.fire_ack = 1'b1;
    @(negedge clk);
    bus.fire_ack = 1'b0;
    chk("fire_req_drop", bus.fire_req, 0);
    for (int i = 0; i < 8; i++) begin
      run_frame(1'b0, 1'b0, 1'b1, 12);
      chk("cooldown_ignore", bus.fire_req, 0);
    end
    run_frame(1'b1, 1'b0, 1'b0, 12);
    chk("pre_fire2_x", ship_x, 306);
    fire = 1'b1;
    n = 0;
    while (!bus.fire_req && n < 20) begin @(negedge clk); n++; end
    chk("fire2_latency", n, 7);
    chk("fire_x_second", bus.fire_x, 322);
    fire = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pending_req", bus.fire_req, 0);
    chk("rst_pending_x", ship_x, 304);
    chk("rst_pending_vel", ship_vel, 0);
    chk("rst_pending_fx", bus.fire_x, 0);
`else
    fire = 1'b1;
    bus.fire_ack = 1'b1;
    repeat (20) @(negedge clk);
    fire = 1'b0;
    bus.fire_ack = 1'b0;
    chk("nofire_req", bus.fire_req, 0);
    chk("nofire_x", bus.fire_x, 0);
    run_frame(1'b1, 1'b0, 1'b0, 12);
    chk("pre_rst_x", ship_x, 306);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_x", ship_x, 304);
    chk("rst_mid_vel", ship_vel, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (mv[i]) begin
      run_frame(mv[i].r, mv[i].l, 1'b0, 12);
      chk("mot_vel", ship_vel, mv[i].vel);
      chk("mot_x", ship_x, mv[i].x);
    end

    n = 0;
    while (ship_x != 12'sd608 && n < 100) begin run_frame(1'b1, 1'b0, 1'b0, 12); n++; end
    chk("rclamp_x", ship_x, 608);
    chk("rclamp_vel", ship_vel, 0);
    for (int i = 0; i < 2; i++) begin
      run_frame(1'b1, 1'b0, 1'b0, 12);
      chk("rclamp_hold_x", ship_x, 608);
      chk("rclamp_hold_vel", ship_vel, 0);
    end

    n = 0;
    while (ship_x != 12'sd12 && n < 100) begin run_frame(1'b0, 1'b1, 1'b0, 12); n++; end
    chk("ltravel_x", ship_x, 12);
    chk("ltravel_vel", ship_vel, -8);
    run_frame(1'b1, 1'b0, 1'b0, 12);
    chk("lapp_vel_a", ship_vel, -6);
    chk("lapp_x_a", ship_x, 6);
    run_frame(1'b0, 1'b0, 1'b0, 12);
    chk("lapp_vel_b", ship_vel, -5);
    chk("lapp_x_b", ship_x, 1);
    run_frame(1'b0, 1'b1, 1'b0, 12);
    chk("lclamp_x", ship_x, 0);
    chk("lclamp_vel", ship_vel, 0);
    run_frame(1'b0, 1'b1, 1'b0, 12);
    chk("lclamp_hold_x", ship_x, 0);
    chk("lclamp_hold_vel", ship_vel, 0);

    run_frame(1'b1, 1'b0, 1'b0, 3);
    chk("glitch_vel", ship_vel, 0);
    chk("glitch_x", ship_x, 0);
    run_frame(1'b1, 1'b0, 1'b0, 12);
    chk("after_glitch_vel", ship_vel, 2);
    chk("after_glitch_x", ship_x, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_ship.md
# player_ship

Parametrised player-ship controller for the gatorga playfield. It is the next generation of the paddle block, adding per-frame velocity with acceleration, friction and saturation, edge clamping that snaps to the boundary, counter-based button debounce, and a fire-request handshake to the projectile spawner. It sits between the button inputs and the video mixer. It emits the ship's pixel colour, an `active` flag and its position for collision and projectile logic.

## Interface
- `HRES`, 640, playfield width in pixels
- `VRES`, 480, playfield height in pixels
- `SHIP_W`, 32, ship width in pixels; must be even
- `SHIP_H`, 16, ship height; the ship occupies rows VRES-SHIP_H..VRES-1
- `MAX_VEL`, 8, velocity magnitude limit in px/frame; range 1..127
- `ACCEL`, 2, velocity change per frame while a direction is held
- `FRICTION`, 1, velocity decay per frame with no direction held
- `DEBOUNCE_CYCLES`, 4, stable cycles needed before a button level is accepted
- `FIRE_COOLDOWN`, 8, frames between an acknowledged shot and the next READY
- `SHIP_COLOR`, 24'h00FF00, RGB colour as {R,G,B}
- `pixel_clk` in 1: the only clock
- `rst_n` in 1: asynchronous, active-low reset
- `fsync` in 1: one-cycle frame-start pulse
- `hpos`, `vpos` in 12 signed: current raster position
- `right`, `left`, `fire` in 1: raw, asynchronous buttons
- `fire_ack` in 1: the spawner has accepted the shot
- `pixel[0:2]` out 8 each: B, G, R; zero when not active
- `active` out 1: raster is inside the ship rectangle
- `ship_x` out 12 signed: left edge of the ship
- `ship_center_x` out 12 signed: equals `ship_x + SHIP_W/2`, combinational
- `ship_vel` out 8 signed: current velocity
- `fire_req` out 1: shot request, held until acknowledged
- `fire_x` out 12 signed: value of `ship_center_x` latched when the request was raised

## Operation
- Debounce:
  - Each button passes through a 2-flop synchroniser.
  - The debounced level changes only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
- Intent latching:
  - Sticky flags `want_r` and `want_l` are set on any cycle whose debounced level is high.
  - Both flags clear on `fsync`.
  - A level seen on the `fsync` cycle counts for the next frame.
- Velocity update on `fsync`:
  - Only `want_r` set: `vel = min(vel + ACCEL, MAX_VEL)`.
  - Only `want_l` set: `vel = max(vel - ACCEL, -MAX_VEL)`.
  - Neither or both set: velocity moves toward 0 by `FRICTION` and never crosses 0.
- Position update on the same `fsync`:
  - `x = ship_x + new_vel`, computed at 13 bits signed.
  - If x < 0: `ship_x = 0` and `vel = 0`.
  - If x > HRES-SHIP_W: `ship_x = HRES-SHIP_W` and `vel = 0`.
- Fire FSM states are READY, PENDING and COOLDOWN:
  - READY to PENDING on a debounced `fire` rising edge. `fire_req` goes to 1 and `fire_x` latches the centre.
  - PENDING to COOLDOWN on `fire_ack`. The counter loads `FIRE_COOLDOWN`.
  - If `FIRE_COOLDOWN` is 0, PENDING goes directly to READY on `fire_ack`.
  - In COOLDOWN the counter decrements on each `fsync`; the FSM returns to READY when it reaches 0.
  - Fire edges outside READY are dropped, not queued.
  - `fire_ack` outside PENDING is ignored.
- Reset values:
  - `ship_x = (HRES-SHIP_W)/2`, which is 304 with defaults; `ship_center_x` is then 320.
  - `ship_vel = 0`, `fire_req = 0`, `fire_x = 0`.
  - Fire FSM in READY; intent flags and debounce state cleared.

## Timing
- `active` and `pixel` are combinational from `hpos`/`vpos` and registered state: zero latency.
- Button press to debounced level: 2 + `DEBOUNCE_CYCLES` cycles.
- Movement applies on the first `fsync` after the intent is latched. `ship_x` and `ship_vel` update one cycle after that `fsync`.
- `fire_req` rises 1 cycle after the debounced edge.
- `fire_req` falls on the cycle after `fire_ack` is sampled high.
- Asserting `rst_n` low mid-frame or mid-handshake immediately forces all reset values, including dropping `fire_req`.

## Configuration
- `PLAYER_SHIP_FIRE_EN` defined: the debouncer and fire FSM are built as described.
- Not defined:
  - No fire logic is built; `fire_req` and `fire_x` are tied to 0.
  - `fire` and `fire_ack` are ignored.
  - The port list is unchanged.

## Structure
- Shared `params` package holds:
  - the `fire_state_t` enum (READY/PENDING/COOLDOWN);
  - the default HRES/VRES;
  - the default ship colour constant.
- Sub-module `btn_debounce`, parametrised by `DEBOUNCE_CYCLES`:
  - contains the synchroniser plus stability counter;
  - has outputs `level` and `rise`;
  - is instantiated once per button (2 or 3 instances).

## Test plan
All scenarios use default parameters.

- Reset, then `hpos=320`, `vpos=470` -> `active=1`, `pixel={00,FF,00}`. At `hpos=300`: `active=0`, all pixel channels 0.
- Hold `right` for 5 frames from reset -> `ship_vel` 2,4,6,8,8 and `ship_x` 306,310,316,324,332. Release -> `ship_vel` 7, `ship_x` 339.
- Hold `right` until clamped -> `ship_x` stays 608 and `ship_vel` reads 0 after every `fsync`. Hold `left` from `ship_x=1` -> `ship_x=0`, `ship_vel=0`.
- Hold `right` and `left` together with `vel=6` -> velocity steps 5,4,… to 0 and never goes negative.
- Press `fire` at `ship_center_x=320` -> `fire_req=1`, `fire_x=320`, held until `fire_ack`. After the ack, a second press is ignored for 8 `fsync`s; a press after that raises `fire_req` again.
- Glitch pulse on `right` of 3 cycles -> no velocity change. Drive `rst_n` low during PENDING -> `fire_req` goes to 0 immediately and `ship_x=304`.
